// File: rtl/ysyx_rob_if.sv
// Bundle of the dispatch, writeback, lookup, commit and flush signals of ysyx_rob.
// The ROB takes the slave side; decode/execute/regfile logic takes the master side.
interface ysyx_rob_if #(
    parameter int XLEN = 32,
    parameter int TW   = 3
);
    logic            dis_valid;
    logic            dis_ready;
    logic [4:0]      dis_rd;
    logic [XLEN-1:0] dis_pc;
    logic [31:0]     dis_inst;
    logic [TW-1:0]   dis_tag;

    logic            wb_valid;
    logic [TW-1:0]   wb_dest;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] wb_npc;
    logic            wb_pc_change;
    logic            wb_ebreak;

    logic [TW-1:0]   lk_tag_a;
    logic [TW-1:0]   lk_tag_b;
    logic            lk_hit_a;
    logic            lk_hit_b;
    logic [XLEN-1:0] lk_data_a;
    logic [XLEN-1:0] lk_data_b;

    logic            cmt_valid;
    logic [4:0]      cmt_rd;
    logic [XLEN-1:0] cmt_data;
    logic [XLEN-1:0] cmt_pc;
    logic [31:0]     cmt_inst;
    logic [TW-1:0]   cmt_tag;
    logic            cmt_ebreak;

    logic            flush;
    logic [XLEN-1:0] flush_pc;

    modport master (
        output dis_valid, dis_rd, dis_pc, dis_inst,
        output wb_valid, wb_dest, wb_result, wb_npc, wb_pc_change, wb_ebreak,
        output lk_tag_a, lk_tag_b,
        input  dis_ready, dis_tag,
        input  lk_hit_a, lk_hit_b, lk_data_a, lk_data_b,
        input  cmt_valid, cmt_rd, cmt_data, cmt_pc, cmt_inst, cmt_tag, cmt_ebreak,
        input  flush, flush_pc
    );

    modport slave (
        input  dis_valid, dis_rd, dis_pc, dis_inst,
        input  wb_valid, wb_dest, wb_result, wb_npc, wb_pc_change, wb_ebreak,
        input  lk_tag_a, lk_tag_b,
        output dis_ready, dis_tag,
        output lk_hit_a, lk_hit_b, lk_data_a, lk_data_b,
        output cmt_valid, cmt_rd, cmt_data, cmt_pc, cmt_inst, cmt_tag, cmt_ebreak,
        output flush, flush_pc
    );
endinterface

// File: rtl/ysyx_rob.sv
// In-order retirement buffer: tag allocation, out-of-order result capture, in-order commit, flush.
// Optional operand forwarding lookup is enabled by defining YSYX_ROB_FWD_EN.
module ysyx_rob #(
    parameter int ROB_SIZE = 4,
    parameter int XLEN     = 32,
    parameter int TW       = $clog2(ROB_SIZE) + 1
) (
    input logic      clock,
    input logic      reset,
    ysyx_rob_if.slave bus
);
    localparam int            IW      = TW - 1;
    localparam logic [TW-1:0] TAG_ONE = TW'(1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [TW-1:0] SIZE_T  = TW'(ROB_SIZE);

    typedef enum logic [1:0] {
        ENT_EMPTY = 2'd0,
        ENT_BUSY  = 2'd1,
        ENT_DONE  = 2'd2
    } ent_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fsm_t;

    ent_t            ent_state_r [ROB_SIZE];
    logic [4:0]      rd_r        [ROB_SIZE];
    logic [XLEN-1:0] pc_r        [ROB_SIZE];
    logic [31:0]     inst_r      [ROB_SIZE];
    logic [XLEN-1:0] result_r    [ROB_SIZE];
    logic [XLEN-1:0] npc_r       [ROB_SIZE];
    logic            pcc_r       [ROB_SIZE];
    logic            ebreak_r    [ROB_SIZE];

    logic [TW-1:0] head_r;
    logic [TW-1:0] tail_r;
    logic [TW-1:0] count_s;
    logic [IW-1:0] head_idx_s;
    logic [IW-1:0] tail_idx_s;
    logic [IW-1:0] wb_idx_s;
    fsm_t          fsm_r;
    fsm_t          fsm_next_s;
    logic          run_s;
    logic          cmt_valid_s;
    logic          flush_s;
    logic          dis_fire_s;
    logic          wb_fire_s;

    // Pointers carry a wrap bit so full and empty are distinguishable from count alone.
    assign count_s     = tail_r - head_r;
    assign head_idx_s  = head_r[IW-1:0];
    assign tail_idx_s  = tail_r[IW-1:0];
    assign wb_idx_s    = bus.wb_dest[IW-1:0] - IDX_ONE;
    assign run_s       = (fsm_r == RUN);
    assign cmt_valid_s = (ent_state_r[head_idx_s] == ENT_DONE) && run_s;
    assign flush_s     = cmt_valid_s && pcc_r[head_idx_s];
    assign dis_fire_s  = bus.dis_valid && bus.dis_ready;
    assign wb_fire_s   = bus.wb_valid && (bus.wb_dest != '0) && (bus.wb_dest <= SIZE_T)
                         && (ent_state_r[wb_idx_s] == ENT_BUSY);

    assign bus.dis_ready = (count_s < SIZE_T) && run_s && !flush_s;
    assign bus.dis_tag   = {1'b0, tail_idx_s} + TAG_ONE;
    assign bus.cmt_valid = cmt_valid_s;
    assign bus.flush     = flush_s;

    // Entry storage and head/tail pointers; a flush empties everything on the next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_r <= '0;
            tail_r <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_state_r[i] <= ENT_EMPTY;
                rd_r[i]        <= 5'd0;
                pc_r[i]        <= '0;
                inst_r[i]      <= 32'd0;
                result_r[i]    <= '0;
                npc_r[i]       <= '0;
                pcc_r[i]       <= 1'b0;
                ebreak_r[i]    <= 1'b0;
            end
        end else if (flush_s) begin
            head_r <= '0;
            tail_r <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_state_r[i] <= ENT_EMPTY;
            end
        end else begin
            if (dis_fire_s) begin
                ent_state_r[tail_idx_s] <= ENT_BUSY;
                rd_r[tail_idx_s]        <= bus.dis_rd;
                pc_r[tail_idx_s]        <= bus.dis_pc;
                inst_r[tail_idx_s]      <= bus.dis_inst;
                tail_r                  <= tail_r + TAG_ONE;
            end
            // Writeback only targets BUSY entries, so it never collides with dispatch or commit.
            if (wb_fire_s) begin
                ent_state_r[wb_idx_s] <= ENT_DONE;
                result_r[wb_idx_s]    <= bus.wb_result;
                npc_r[wb_idx_s]       <= bus.wb_npc;
                pcc_r[wb_idx_s]       <= bus.wb_pc_change;
                ebreak_r[wb_idx_s]    <= bus.wb_ebreak;
            end
            if (cmt_valid_s) begin
                ent_state_r[head_idx_s] <= ENT_EMPTY;
                head_r                  <= head_r + TAG_ONE;
            end
        end
    end

    // Global run/halt state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_r <= RUN;
        end else begin
            fsm_r <= fsm_next_s;
        end
    end

    // Halt once an ebreak retires; only reset brings the block back to RUN.
    always_comb begin
        fsm_next_s = fsm_r;
        case (fsm_r)
            RUN: begin
                if (cmt_valid_s && ebreak_r[head_idx_s]) begin
                    fsm_next_s = HALT;
                end else begin
                    fsm_next_s = RUN;
                end
            end
            HALT:    fsm_next_s = HALT;
            default: fsm_next_s = RUN;
        endcase
    end

    // Retire payload is driven from the head entry only while it is actually retiring.
    always_comb begin
        bus.cmt_rd     = 5'd0;
        bus.cmt_data   = '0;
        bus.cmt_pc     = '0;
        bus.cmt_inst   = 32'd0;
        bus.cmt_tag    = '0;
        bus.cmt_ebreak = 1'b0;
        bus.flush_pc   = '0;
        if (cmt_valid_s) begin
            bus.cmt_rd     = rd_r[head_idx_s];
            bus.cmt_data   = result_r[head_idx_s];
            bus.cmt_pc     = pc_r[head_idx_s];
            bus.cmt_inst   = inst_r[head_idx_s];
            bus.cmt_tag    = {1'b0, head_idx_s} + TAG_ONE;
            bus.cmt_ebreak = ebreak_r[head_idx_s];
            bus.flush_pc   = pcc_r[head_idx_s] ? npc_r[head_idx_s] : '0;
        end else begin
            bus.cmt_rd     = 5'd0;
            bus.flush_pc   = '0;
        end
    end

`ifdef YSYX_ROB_FWD_EN
    logic [IW-1:0] lk_idx_a_s;
    logic [IW-1:0] lk_idx_b_s;

    assign lk_idx_a_s = bus.lk_tag_a[IW-1:0] - IDX_ONE;
    assign lk_idx_b_s = bus.lk_tag_b[IW-1:0] - IDX_ONE;

    // Returns {hit, data}; a same-cycle writeback to the tag wins over the stored result.
    function automatic logic [XLEN:0] lookup_f(
        input logic [TW-1:0]   tag,
        input ent_t            st,
        input logic [XLEN-1:0] stored,
        input logic            wbv,
        input logic [TW-1:0]   wbd,
        input logic [XLEN-1:0] wbr
    );
        logic [XLEN:0] res;
        res = '0;
        if ((tag == '0) || (tag > SIZE_T)) begin
            res = '0;
        end else if (wbv && (wbd == tag)) begin
            res = {1'b1, wbr};
        end else if (st == ENT_DONE) begin
            res = {1'b1, stored};
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Operand lookup for both source ports.
    always_comb begin
        {bus.lk_hit_a, bus.lk_data_a} = lookup_f(bus.lk_tag_a, ent_state_r[lk_idx_a_s],
                                                 result_r[lk_idx_a_s], bus.wb_valid,
                                                 bus.wb_dest, bus.wb_result);
        {bus.lk_hit_b, bus.lk_data_b} = lookup_f(bus.lk_tag_b, ent_state_r[lk_idx_b_s],
                                                 result_r[lk_idx_b_s], bus.wb_valid,
                                                 bus.wb_dest, bus.wb_result);
    end
`else
    logic unused_lk_s;

    assign unused_lk_s   = ^{bus.lk_tag_a, bus.lk_tag_b};
    assign bus.lk_hit_a  = 1'b0;
    assign bus.lk_hit_b  = 1'b0;
    assign bus.lk_data_a = '0;
    assign bus.lk_data_b = '0;
`endif

endmodule

// File: tb/tb_ysyx_rob.sv
// Scoreboard bench for ysyx_rob: expected commits are queued at dispatch and checked at retire.
module tb_ysyx_rob;
    localparam int ROB_SIZE = 4;
    localparam int XLEN     = 32;
    localparam int TW       = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    ysyx_rob_if #(.XLEN(XLEN), .TW(TW)) bus ();

    ysyx_rob #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .TW(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]    rd;
        logic [31:0]   data;
        logic [31:0]   pc;
        logic [TW-1:0] tag;
        logic          eb;
        logic          fl;
        logic [31:0]   npc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dis_valid    = 1'b0;
        bus.dis_rd       = 5'd0;
        bus.dis_pc       = 32'd0;
        bus.dis_inst     = 32'd0;
        bus.wb_valid     = 1'b0;
        bus.wb_dest      = 3'd0;
        bus.wb_result    = 32'd0;
        bus.wb_npc       = 32'd0;
        bus.wb_pc_change = 1'b0;
        bus.wb_ebreak    = 1'b0;
        bus.lk_tag_a     = 3'd0;
        bus.lk_tag_b     = 3'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    function automatic logic [31:0] pc_of(input logic [4:0] rd);
        return 32'h8000_0000 + (32'(rd) << 2);
    endfunction

    task automatic dispatch(input logic [4:0] rd, input logic [TW-1:0] tag, input logic [31:0] data,
                            input logic eb, input logic fl, input logic [31:0] npc);
        exp_t e;
        bus.dis_valid = 1'b1;
        bus.dis_rd    = rd;
        bus.dis_pc    = pc_of(rd);
        bus.dis_inst  = {20'h0, rd, 7'h13};
        #1;
        check_eq("dis_ready", {63'd0, bus.dis_ready}, 64'd1);
        check_eq("dis_tag", {61'd0, bus.dis_tag}, {61'd0, tag});
        e.rd = rd; e.data = data; e.pc = pc_of(rd); e.tag = tag;
        e.eb = eb; e.fl = fl; e.npc = npc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.dis_valid = 1'b0;
    endtask

    task automatic writeback(input logic [TW-1:0] tag, input logic [31:0] res,
                             input logic pcc, input logic eb, input logic [31:0] npc);
        bus.wb_valid     = 1'b1;
        bus.wb_dest      = tag;
        bus.wb_result    = res;
        bus.wb_pc_change = pcc;
        bus.wb_ebreak    = eb;
        bus.wb_npc       = npc;
        @(posedge clock);
        #1;
        bus.wb_valid     = 1'b0;
        bus.wb_pc_change = 1'b0;
        bus.wb_ebreak    = 1'b0;
    endtask

    // Retire monitor: every commit must match the oldest outstanding dispatch.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.cmt_valid) begin
                if (sb.size() == 0) begin
                    check_eq("cmt_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("cmt_rd", {59'd0, bus.cmt_rd}, {59'd0, mon_e.rd});
                    check_eq("cmt_data", {32'd0, bus.cmt_data}, {32'd0, mon_e.data});
                    check_eq("cmt_pc", {32'd0, bus.cmt_pc}, {32'd0, mon_e.pc});
                    check_eq("cmt_tag", {61'd0, bus.cmt_tag}, {61'd0, mon_e.tag});
                    check_eq("cmt_ebreak", {63'd0, bus.cmt_ebreak}, {63'd0, mon_e.eb});
                    check_eq("cmt_flush", {63'd0, bus.flush}, {63'd0, mon_e.fl});
                    if (mon_e.fl) begin
                        check_eq("flush_pc", {32'd0, bus.flush_pc}, {32'd0, mon_e.npc});
                    end
                    if (mon_e.fl || mon_e.eb) begin
                        sb.delete();
                    end
                end
            end else if (bus.flush) begin
                check_eq("flush_without_commit", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();

        // reset values
        check_eq("rst_dis_ready", {63'd0, bus.dis_ready}, 64'd1);
        check_eq("rst_dis_tag", {61'd0, bus.dis_tag}, 64'd1);
        check_eq("rst_cmt_valid", {63'd0, bus.cmt_valid}, 64'd0);
        check_eq("rst_cmt_rd", {59'd0, bus.cmt_rd}, 64'd0);
        check_eq("rst_cmt_data", {32'd0, bus.cmt_data}, 64'd0);
        check_eq("rst_flush", {63'd0, bus.flush}, 64'd0);
        check_eq("rst_flush_pc", {32'd0, bus.flush_pc}, 64'd0);
        check_eq("rst_lk_hit_a", {63'd0, bus.lk_hit_a}, 64'd0);
        check_eq("rst_lk_data_a", {32'd0, bus.lk_data_a}, 64'd0);

        // fill with no writeback
        for (int i = 1; i <= 4; i++) begin
            dispatch(5'(i), 3'(i), 32'(i) * 32'h11, 1'b0, 1'b0, 32'd0);
        end
        check_eq("full_dis_ready", {63'd0, bus.dis_ready}, 64'd0);
        check_eq("full_cmt_valid", {63'd0, bus.cmt_valid}, 64'd0);
        repeat (2) tick();
        check_eq("busy_no_commit", {63'd0, bus.cmt_valid}, 64'd0);

        // out-of-order writeback, in-order retire
        writeback(3'd3, 32'h33, 1'b0, 1'b0, 32'd0);
        writeback(3'd1, 32'h11, 1'b0, 1'b0, 32'd0);
        writeback(3'd2, 32'h22, 1'b0, 1'b0, 32'd0);
        repeat (3) tick();
        check_eq("ooo_remaining", 64'(sb.size()), 64'd1);
        writeback(3'd4, 32'h44, 1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        check_eq("drain_all", 64'(sb.size()), 64'd0);

        // full with commit in the same cycle: dispatch refused, then tail wraps to tag 1
        for (int i = 1; i <= 4; i++) begin
            dispatch(5'(i + 4), 3'(i), 32'(i + 4) * 32'h11, 1'b0, 1'b0, 32'd0);
        end
        check_eq("full2_dis_ready", {63'd0, bus.dis_ready}, 64'd0);
        writeback(3'd1, 32'h55, 1'b0, 1'b0, 32'd0);
        bus.dis_valid = 1'b1;
        bus.dis_rd    = 5'd9;
        bus.dis_pc    = pc_of(5'd9);
        #1;
        check_eq("full_commit_cmt", {63'd0, bus.cmt_valid}, 64'd1);
        check_eq("full_commit_ready", {63'd0, bus.dis_ready}, 64'd0);
        tick();
        bus.dis_valid = 1'b0;
        #1;
        check_eq("wrap_dis_ready", {63'd0, bus.dis_ready}, 64'd1);
        check_eq("wrap_dis_tag", {61'd0, bus.dis_tag}, 64'd1);

        // asynchronous reset mid-operation
        reset = 1'b1;
        #1;
        check_eq("async_rst_cmt", {63'd0, bus.cmt_valid}, 64'd0);
        check_eq("async_rst_tag", {61'd0, bus.dis_tag}, 64'd1);
        do_reset();

        // mispredict flush with younger entries busy
        dispatch(5'd1, 3'd1, 32'h11, 1'b0, 1'b1, 32'h8000_0100);
        dispatch(5'd2, 3'd2, 32'h22, 1'b0, 1'b0, 32'd0);
        dispatch(5'd3, 3'd3, 32'h33, 1'b0, 1'b0, 32'd0);
        writeback(3'd1, 32'h11, 1'b1, 1'b0, 32'h8000_0100);
        bus.dis_valid = 1'b1;
        bus.dis_rd    = 5'd4;
        bus.wb_valid  = 1'b1;
        bus.wb_dest   = 3'd2;
        bus.wb_result = 32'h22;
        #1;
        check_eq("flush_active", {63'd0, bus.flush}, 64'd1);
        check_eq("flush_pc_val", {32'd0, bus.flush_pc}, 64'h8000_0100);
        check_eq("flush_dis_ready", {63'd0, bus.dis_ready}, 64'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("post_flush", {63'd0, bus.flush}, 64'd0);
        check_eq("post_flush_tag", {61'd0, bus.dis_tag}, 64'd1);
        check_eq("post_flush_ready", {63'd0, bus.dis_ready}, 64'd1);
        check_eq("post_flush_cmt", {63'd0, bus.cmt_valid}, 64'd0);
        writeback(3'd2, 32'h22, 1'b0, 1'b0, 32'd0);
        tick();
        check_eq("wb_empty_ignored", {63'd0, bus.cmt_valid}, 64'd0);
        check_eq("wb_empty_tag", {61'd0, bus.dis_tag}, 64'd1);

        // ebreak halts retirement and dispatch
        dispatch(5'd7, 3'd1, 32'h77, 1'b1, 1'b0, 32'd0);
        dispatch(5'd8, 3'd2, 32'h88, 1'b0, 1'b0, 32'd0);
        writeback(3'd2, 32'h88, 1'b0, 1'b0, 32'd0);
        writeback(3'd1, 32'h77, 1'b0, 1'b1, 32'd0);
        check_eq("ebreak_cmt", {63'd0, bus.cmt_ebreak}, 64'd1);
        tick();
        check_eq("halt_cmt_valid", {63'd0, bus.cmt_valid}, 64'd0);
        check_eq("halt_dis_ready", {63'd0, bus.dis_ready}, 64'd0);
        repeat (3) tick();
        check_eq("halt_hold_cmt", {63'd0, bus.cmt_valid}, 64'd0);
        check_eq("halt_hold_ready", {63'd0, bus.dis_ready}, 64'd0);

        // operand lookup with same-cycle writeback bypass
        do_reset();
        dispatch(5'd9, 3'd1, 32'h99, 1'b0, 1'b0, 32'd0);
        dispatch(5'd10, 3'd2, 32'hABCD, 1'b0, 1'b0, 32'd0);
        bus.lk_tag_a  = 3'd2;
        bus.lk_tag_b  = 3'd1;
        bus.wb_valid  = 1'b1;
        bus.wb_dest   = 3'd2;
        bus.wb_result = 32'hABCD;
        #1;
`ifdef YSYX_ROB_FWD_EN
        check_eq("lk_bypass_hit", {63'd0, bus.lk_hit_a}, 64'd1);
        check_eq("lk_bypass_data", {32'd0, bus.lk_data_a}, 64'hABCD);
`else
        check_eq("lk_off_hit", {63'd0, bus.lk_hit_a}, 64'd0);
        check_eq("lk_off_data", {32'd0, bus.lk_data_a}, 64'd0);
`endif
        check_eq("lk_busy_miss", {63'd0, bus.lk_hit_b}, 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
`ifdef YSYX_ROB_FWD_EN
        check_eq("lk_stored_hit", {63'd0, bus.lk_hit_a}, 64'd1);
        check_eq("lk_stored_data", {32'd0, bus.lk_data_a}, 64'hABCD);
`else
        check_eq("lk_off_hit2", {63'd0, bus.lk_hit_a}, 64'd0);
`endif
        writeback(3'd1, 32'h99, 1'b0, 1'b0, 32'd0);
        repeat (3) tick();
        check_eq("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_rob.md
# ysyx_rob

In-order retirement buffer directly downstream of the execute stage. It allocates a tag per dispatched instruction, captures execute results out of order by tag, and retires them one per cycle in program order to the register file. It raises a pipeline flush on a mispredicted control transfer. Its tag encoding is the one carried in the decode/execute pipe signals (`qj`, `qk`, `dest`), where tag 0 means no pending producer.

## Interface
Parameters:
- `ROB_SIZE`, 4: number of entries; power of two, minimum 2.
- `XLEN`, 32: data and PC width.
- `TW`, $clog2(ROB_SIZE)+1: tag width. tag = entry index + 1; tag 0 is reserved for "none".

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `dis_valid` in 1: decode offers an instruction.
- `dis_ready` out 1: an entry is free and the block is in RUN.
- `dis_rd` in 5, `dis_pc` in XLEN, `dis_inst` in 32: dispatch payload.
- `dis_tag` out TW: tag assigned to the offered instruction, tail index + 1.
- `wb_valid` in 1, `wb_dest` in TW: execute result valid and its tag.
- `wb_result` in XLEN, `wb_npc` in XLEN, `wb_pc_change` in 1, `wb_ebreak` in 1: result payload.
- `lk_tag_a`, `lk_tag_b` in TW: operand lookup tags.
- `lk_hit_a`, `lk_hit_b` out 1, `lk_data_a`, `lk_data_b` out XLEN: lookup results.
- `cmt_valid` out 1: head entry retires this cycle.
- `cmt_rd` out 5, `cmt_data` out XLEN, `cmt_pc` out XLEN, `cmt_inst` out 32, `cmt_tag` out TW, `cmt_ebreak` out 1: retire payload.
- `flush` out 1, `flush_pc` out XLEN: redirect on mispredict.

## Operation
- Each entry has a state: EMPTY, BUSY (dispatched, no result yet), or DONE (result captured). Each entry also stores rd, pc, inst, result, npc, pc_change, and ebreak.
- Head and tail are TW-bit pointers that include a wrap bit. Count = tail − head.
- Global FSM has two states:
  - RUN to HALT: when an entry with ebreak=1 commits.
  - HALT to RUN: only on reset.
- `dis_ready` = (count < ROB_SIZE) && RUN && !flush.
- Dispatch fires when `dis_valid && dis_ready`. The tail entry becomes BUSY with its payload, and tail increments modulo 2·ROB_SIZE.
- Writeback:
  - When `wb_valid`, `wb_dest != 0`, and the target entry is BUSY, the entry becomes DONE and captures the payload.
  - Writeback with tag 0, to an EMPTY entry, or to a DONE entry is ignored.
- Commit:
  - `cmt_valid` = head entry DONE && RUN. Payload is driven from the head entry.
  - On commit, the head entry becomes EMPTY and head increments.
  - Dispatch and commit in the same cycle are allowed; count is unchanged.
- Flush:
  - `flush` = `cmt_valid` && head.pc_change, and `flush_pc` = head.npc.
  - On the next edge, all entries become EMPTY and head and tail are set to 0.
  - A dispatch or writeback presented in the flush cycle is discarded.
- Ebreak: `cmt_ebreak` = head.ebreak during commit. From the next cycle, `cmt_valid` and `dis_ready` stay 0.
- Full (count = ROB_SIZE): dispatch is refused, even if a commit occurs in the same cycle.
- Empty: `cmt_valid` = 0.

## Timing
- Reset values:
  - outputs: `dis_ready`=1, `dis_tag`=1, `cmt_valid`=0, `cmt_*`=0, `flush`=0, `flush_pc`=0, `lk_hit_*`=0, `lk_data_*`=0.
  - internal: all entries EMPTY, head=tail=0, FSM in RUN.
- `dis_tag`, `dis_ready`, `cmt_*`, `flush`, and `lk_*` are combinational from registered state (plus the `wb_*` bypass for `lk_*`).
- Dispatch at cycle N means the entry is BUSY from N+1. The earliest accepted writeback is at N+1.
- Writeback at cycle M gives the earliest commit at M+1, so minimum dispatch-to-commit is 2 cycles.
- Flush lasts exactly one cycle. The next dispatch is possible at flush+1, with `dis_tag`=1.
- Reset asserted mid-operation clears everything immediately; no partial commit is visible.

## Configuration
- `YSYX_ROB_FWD_EN` defined:
  - `lk_hit_x` = `lk_tag_x != 0` && (entry DONE || (`wb_valid` && `wb_dest == lk_tag_x`)).
  - `lk_data_x` = the same-cycle `wb_result` when it matches, otherwise the stored result.
- `YSYX_ROB_FWD_EN` undefined: `lk_hit_*`=0 and `lk_data_*`=0 constantly. Consumers must wait for commit.

## Test plan
- Reset, then dispatch 4 instructions with rd=1..4 and no writeback -> tags 1,2,3,4; `dis_ready`=0 after the 4th; `cmt_valid` stays 0.
- Writeback out of order (tag 3 result 0x33, tag 1 0x11, tag 2 0x22) -> commits rd=1/0x11, rd=2/0x22, rd=3/0x33 on consecutive cycles, in order.
- Full ROB, commit head while `dis_valid`=1 -> no dispatch that cycle; next cycle `dis_ready`=1 and `dis_tag`=1 (tail wrapped).
- Tag 1 writes back with pc_change=1 and npc=0x80000100 while tags 2 and 3 are BUSY -> `flush`=1 and `flush_pc`=0x80000100 for one cycle; then empty with `dis_tag`=1; a later writeback to tag 2 is ignored.
- Commit an entry with ebreak=1 -> `cmt_ebreak`=1 once; afterwards `cmt_valid`=0 and `dis_ready`=0 despite DONE entries, until reset.
- With `YSYX_ROB_FWD_EN`: `lk_tag_a`=2 while `wb_dest`=2 and `wb_result`=0xABCD in the same cycle -> `lk_hit_a`=1, `lk_data_a`=0xABCD. Without the macro -> `lk_hit_a`=0.
